// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, opcodes, FSM states and the ALU reference model
package alu_seq_pkg;
  localparam int DW = 32;
  localparam int OPW = 4;
  localparam logic [OPW-1:0] OP_AND = 4'b0000;
  localparam logic [OPW-1:0] OP_OR  = 4'b0001;
  localparam logic [OPW-1:0] OP_ADD = 4'b0010;
  localparam logic [OPW-1:0] OP_SUB = 4'b0110;
  localparam logic [OPW-1:0] OP_SLT = 4'b0111;
  localparam logic [OPW-1:0] OP_NOR = 4'b1100;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  // Returns {cout, zero, result}; SUB is a + ~b + 1 so its carry is "no borrow"
  function automatic logic [DW+1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [OPW-1:0] op);
    logic [DW:0] s;
    logic [DW-1:0] r;
    s = (op == OP_SUB) ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b};
    r = op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_SLT ? {{(DW-1){1'b0}}, $signed(a) < $signed(b)} :
        op == OP_NOR ? ~(a | b) : s[DW-1:0];
    return {s[DW], r == '0, r};
  endfunction
endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: synchronous request FIFO with full/empty flags
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + ONE;
      if (pop) rp <= rp + ONE;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/alu_request_sequencer.sv
// alu_request_sequencer: queues ALU requests, drives operands, captures results after a settle time
// Define ALU_SELFCHECK_EN to add the reference-model check behind mismatch/err_count.
module alu_request_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [DW-1:0]  req_a,
  input  logic [DW-1:0]  req_b,
  input  logic [OPW-1:0] req_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_cout,
  input  logic           alu_zero,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_cout,
  output logic           rsp_zero,
  output logic           busy,
  output logic           mismatch,
  output logic [15:0]    err_count
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2*DW+OPW-1:0] head;
  logic full, empty, pop, cap;
  assign req_ready = !full;
  assign pop = !empty && (state == IDLE || (state == RESP && rsp_ready));
  assign cap = state == SETTLE && cnt == '0;
  assign busy = state != IDLE || !empty;
  alu_req_fifo #(.DEPTH(DEPTH), .W(2*DW+OPW)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(req_valid && !full), .pop(pop),
    .din({req_a, req_b, req_op}), .dout(head), .full(full), .empty(empty)
  );
  always_comb begin
    state_nx = state;
    if (state == IDLE && pop) state_nx = SETTLE;
    if (cap) state_nx = RESP;
    if (state == RESP && rsp_ready) state_nx = empty ? IDLE : SETTLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_cout <= 1'b0;
      rsp_zero <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        {alu_a, alu_b, alu_op} <= head;
        cnt <= CNT_LOAD;
      end else if (state == SETTLE && cnt != '0) cnt <= cnt - CNT_ONE;
      if (cap) begin
        rsp_result <= alu_result;
        rsp_cout <= alu_cout;
        rsp_zero <= alu_zero;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
`ifdef ALU_SELFCHECK_EN
  logic [DW+1:0] exp_v;
  logic chk, diff;
  assign exp_v = alu_ref(alu_a, alu_b, alu_op);
  assign chk = alu_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
  assign diff = alu_result != exp_v[DW-1:0] || alu_zero != exp_v[DW] ||
                ((alu_op == OP_ADD || alu_op == OP_SUB) && alu_cout != exp_v[DW+1]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mismatch <= 1'b0;
      err_count <= '0;
    end else if (cap && chk && diff) begin
      mismatch <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
`else
  assign mismatch = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_alu_request_sequencer.sv
// tb_alu_request_sequencer: scoreboard bench with a behavioural ALU stub and fault injection
module tb_alu_request_sequencer;
  localparam int S = 2;
  typedef struct packed {logic [31:0] r; logic c; logic z;} exp_t;
  logic clk = 0, rst_n = 0, req_valid = 0, rsp_ready = 0, inject = 0;
  logic req_ready, rsp_valid, rsp_cout, rsp_zero, busy, mismatch, alu_cout, alu_zero;
  logic [31:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_result, rsp_result;
  logic [3:0] req_op = 0, alu_op;
  logic [15:0] err_count;
  exp_t q[$];
  exp_t stub;
  int total = 0, pass = 0;

  always #5 clk = ~clk;

  alu_request_sequencer #(.DEPTH(4), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy),
    .mismatch(mismatch), .err_count(err_count)
  );

  function automatic exp_t alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] s;
    exp_t e;
    s = 33'd0;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: s = {1'b0, a} + {1'b0, b};
      4'b0110: s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      4'b0111: e.r = {31'd0, $signed(a) < $signed(b)};
      4'b1100: e.r = ~(a | b);
      default: e.r = a ^ b;
    endcase
    if (op == 4'b0010 || op == 4'b0110) e.r = s[31:0];
    e.c = s[32];
    e.z = e.r == 32'd0;
    return e;
  endfunction

  always_comb begin
    stub = alu_fn(alu_a, alu_b, alu_op);
    if (inject && alu_op == 4'b0010) stub.r[0] = ~stub.r[0];
  end
  assign {alu_result, alu_cout, alu_zero} = stub;

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int t = 0;
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1;
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) begin total++; $display("FAIL push_timeout req_ready=%b want 1", req_ready); end
    else q.push_back(alu_fn(a, b, op));
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({req_ready, busy, rsp_valid, rsp_cout, rsp_zero, mismatch} !== 6'b100000)
      $display("FAIL reset_flags got %b want 100000", {req_ready, busy, rsp_valid, rsp_cout, rsp_zero, mismatch});
    else pass++;
    total++;
    if ({alu_a, alu_b, alu_op, rsp_result, err_count} !== '0)
      $display("FAIL reset_data alu_a=%h alu_b=%h alu_op=%h rsp=%h err=%0d want 0", alu_a, alu_b, alu_op, rsp_result, err_count);
    else pass++;
  endtask

  task automatic test_add_latency;
    int k = 0;
    exp_t e;
    rsp_ready = 1;
    push(32'd5, 32'd7, 4'b0010);
    @(negedge clk);
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    total++;
    if (k !== S + 1) $display("FAIL add_latency got %0d want %0d", k, S + 1); else pass++;
    e = q.pop_front();
    total++;
    if ({rsp_valid, rsp_result, rsp_cout, rsp_zero} !== {1'b1, 32'd12, 1'b0, 1'b0})
      $display("FAIL add_result valid=%b res=%0d c=%b z=%b want 1/12/0/0", rsp_valid, rsp_result, rsp_cout, rsp_zero);
    else pass++;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) $display("FAIL add_consumed rsp_valid=%b want 0", rsp_valid); else pass++;
  endtask

  task automatic test_flags;
    exp_t want[2];
    exp_t e;
    int t;
    want[0] = {32'd0, 1'b1, 1'b1};
    want[1] = {32'd0, 1'b1, 1'b1};
    rsp_ready = 1;
    push(32'd5, 32'd5, 4'b0110);
    push(32'hFFFFFFFF, 32'd1, 4'b0010);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
      e = q.pop_front();
      total++;
      if (!rsp_valid || {rsp_result, rsp_cout, rsp_zero} !== want[i])
        $display("FAIL flags_%0d valid=%b got %h/%b/%b want %h/%b/%b", i, rsp_valid, rsp_result, rsp_cout, rsp_zero, want[i].r, want[i].c, want[i].z);
      else pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int t;
    rsp_ready = 0;
    push(32'hFFFF0000, 32'h00FF00FF, 4'b0000);
    push(32'd12, 32'd3, 4'b0001);
    push(32'hFFFFFFFD, 32'd2, 4'b0111);
    push(32'd0, 32'd0, 4'b1100);
    push(32'h0000000A, 32'h0000000B, 4'b1111);
    @(negedge clk);
    total++;
    if ({req_ready, busy} !== 2'b01) $display("FAIL b2b_full req_ready=%b busy=%b want 0 1", req_ready, busy); else pass++;
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      t = 0;
      while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
      e = q.pop_front();
      total++;
      if (!rsp_valid || {rsp_result, rsp_cout, rsp_zero} !== e)
        $display("FAIL b2b_%0d valid=%b got %h/%b/%b want %h/%b/%b", i, rsp_valid, rsp_result, rsp_cout, rsp_zero, e.r, e.c, e.z);
      else pass++;
      @(negedge clk);
    end
    total++;
    if ({mismatch, err_count} !== 17'd0) $display("FAIL b2b_selfcheck mismatch=%b err=%0d want 0 0", mismatch, err_count); else pass++;
  endtask

  task automatic test_hold;
    exp_t e;
    int t = 0;
    rsp_ready = 0;
    push(32'd9, 32'd10, 4'b0010);
    for (int i = 0; i < 4; i++) push(32'd100 + i, 32'd1, 4'b0110);
    @(negedge clk);
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({rsp_valid, rsp_result, rsp_cout, rsp_zero, alu_a, alu_b, alu_op, req_ready} !==
          {1'b1, 32'd19, 1'b0, 1'b0, 32'd9, 32'd10, 4'b0010, 1'b0})
        $display("FAIL hold_%0d valid=%b res=%0d alu_a=%0d alu_b=%0d op=%h req_ready=%b want 1/19/9/10/2/0",
                 i, rsp_valid, rsp_result, alu_a, alu_b, alu_op, req_ready);
      else pass++;
      @(negedge clk);
    end
    rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      t = 0;
      while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
      e = q.pop_front();
      total++;
      if (!rsp_valid || {rsp_result, rsp_cout, rsp_zero} !== e)
        $display("FAIL hold_drain_%0d valid=%b got %h/%b/%b want %h/%b/%b", i, rsp_valid, rsp_result, rsp_cout, rsp_zero, e.r, e.c, e.z);
      else pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int t = 0;
    logic seen = 0;
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) push(32'd20 + i, 32'd3, 4'b0010);
    @(negedge clk);
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    total++;
    if ({busy, rsp_valid, req_ready} !== 3'b101) $display("FAIL rmid_settle busy=%b valid=%b ready=%b want 1 0 1", busy, rsp_valid, req_ready); else pass++;
    rst_n = 0;
    #1;
    total++;
    if ({req_ready, busy, rsp_valid, rsp_cout, rsp_zero, mismatch, alu_a, alu_b, alu_op, rsp_result, err_count} !== {1'b1, 121'd0})
      $display("FAIL rmid_reset ready=%b busy=%b valid=%b alu_a=%h rsp=%h want 1 0 0 0 0", req_ready, busy, rsp_valid, alu_a, rsp_result);
    else pass++;
    q.delete();
    @(negedge clk);
    rst_n = 1;
    rsp_ready = 1;
    repeat (12) begin @(negedge clk); seen = seen | rsp_valid | busy; end
    total++;
    if (seen !== 1'b0) $display("FAIL rmid_no_rsp activity=%b want 0", seen); else pass++;
  endtask

  task automatic test_selfcheck;
    int t = 0;
    exp_t e;
    inject = 1;
    rsp_ready = 1;
    push(32'd2, 32'd2, 4'b0010);
    q[q.size() - 1] = {32'd5, 1'b0, 1'b0};
    @(negedge clk);
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    e = q.pop_front();
    total++;
    if (!rsp_valid || {rsp_result, rsp_cout, rsp_zero} !== e)
      $display("FAIL sc_result valid=%b got %h want %h", rsp_valid, rsp_result, e.r);
    else pass++;
    total++;
`ifdef ALU_SELFCHECK_EN
    if ({mismatch, err_count} !== {1'b1, 16'd1})
`else
    if ({mismatch, err_count} !== {1'b0, 16'd0})
`endif
      $display("FAIL sc_flag mismatch=%b err_count=%0d", mismatch, err_count);
    else pass++;
    inject = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1;
    test_add_latency;
    test_flags;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    test_selfcheck;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
